aes_vector_sequencer: RTL and testbench

- Synthesizable, parametrised test-vector sequencer that drives an AES_top-style core and checks its responses.
- Replaces hand-timed testbench stimulus for on-silicon and gate-level (SDF) runs.
- Fetches NUM_VEC vectors from an external table, issues each to the core with AES_en held, and waits for AES_data_out_valid with a timeout.
- Compares each result against the expected ciphertext and accumulates pass/fail/timeout status.

---
 rtl/aes_vector_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_aes_vector_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_vector_sequencer.sv
// ---------------------------------------------------------------------------
// aes_vector_sequencer
//
// Purpose:
//   Walks a table of NUM_VEC test vectors and issues each one to an
//   AES_top-style core. For every vector it registers the plaintext and key,
//   holds AES_en high until the core answers with AES_data_out_valid or a
//   timeout expires, and compares the answer with the expected ciphertext.
//   Pass, fail and timeout results are accumulated for the whole run.
//
// Handshake with the core:
//   The core interface has no ready. AES_en is a level that is high exactly
//   while a vector is in flight, which is every RUN cycle. A response is taken
//   only in a cycle where AES_en is high and AES_data_out_valid is high.
//   AES_data_out_valid in any other cycle is ignored.
//
// Ports:
//   AES_clk, AES_rst     clock; asynchronous active-high reset
//   AES_start            start-run pulse, honoured only in IDLE or DONE
//   AES_vec_idx          index of the vector being fetched from the table
//   AES_vec_data/key/expect  combinational table lookup for AES_vec_idx
//   AES_en               core enable (registered)
//   AES_data_in/key_in   registered plaintext / key to the core
//   AES_data_out(_valid) core result and its valid strobe
//   AES_busy, AES_done   run status levels
//   AES_pass_cnt/fail_cnt  saturating result counters
//   AES_timeout_flag     sticky, set when any vector timed out
//   AES_first_fail_idx   index of the first failing vector
//   AES_dbg_state        current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module aes_vector_sequencer #(
    parameter int DATA_W     = 128,
    parameter int KEY_W      = 128,
    parameter int NUM_VEC    = 4,
    parameter int IDX_W      = 2,
    parameter int TIMEOUT    = 63,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              AES_start,
    output logic [IDX_W-1:0]  AES_vec_idx,
    input  logic [DATA_W-1:0] AES_vec_data,
    input  logic [KEY_W-1:0]  AES_vec_key,
    input  logic [DATA_W-1:0] AES_vec_expect,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [KEY_W-1:0]  AES_key_in,
    input  logic [DATA_W-1:0] AES_data_out,
    input  logic              AES_data_out_valid,
    output logic              AES_busy,
    output logic              AES_done,
    output logic [CNT_W-1:0]  AES_pass_cnt,
    output logic [CNT_W-1:0]  AES_fail_cnt,
    output logic              AES_timeout_flag,
    output logic [IDX_W-1:0]  AES_first_fail_idx,
    output logic [2:0]        AES_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // One spare bit so the incremented wait count can reach TIMEOUT+1
    // without wrapping.
    localparam int WAIT_W = $clog2(TIMEOUT + 2);
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [WAIT_W-1:0]   r_wait;
    logic [GAP_W-1:0]    r_gap;
    logic [DATA_W-1:0]   r_expect;
    logic [DATA_W-1:0]   r_result;
    logic                r_en;
    logic [DATA_W-1:0]   r_data_in;
    logic [KEY_W-1:0]    r_key_in;
    logic [CNT_W-1:0]    r_pass;
    logic [CNT_W-1:0]    r_fail;
    logic                r_tflag;
    logic [IDX_W-1:0]    r_ff_idx;
    logic                r_busy;
    logic                r_done;

    logic [WAIT_W-1:0]   w_wait_next;
    logic                w_timeout;
    logic                w_match;
    logic [CNT_W-1:0]    w_pass_inc;
    logic [CNT_W-1:0]    w_fail_inc;

    // The wait counter is compared after incrementing, so the timeout fires
    // in the TIMEOUT-th RUN cycle (the counter is cleared in LOAD).
    assign w_wait_next = r_wait + WAIT_W'(1);
    assign w_timeout   = (w_wait_next == TIMEOUT_V);
    assign w_match     = (r_result == r_expect);

    // Saturating increments: hold at all-ones instead of wrapping.
    assign w_pass_inc  = (r_pass == CNT_MAX) ? r_pass : r_pass + CNT_W'(1);
    assign w_fail_inc  = (r_fail == CNT_MAX) ? r_fail : r_fail + CNT_W'(1);

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_wait   <= '0;
            r_gap    <= '0;
            r_expect <= '0;
            r_result <= '0;
            r_en     <= 1'b0;
            r_data_in <= '0;
            r_key_in <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_tflag  <= 1'b0;
            r_ff_idx <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_en <= 1'b0;
                    if (AES_start) begin
                        r_pass   <= '0;
                        r_fail   <= '0;
                        r_tflag  <= 1'b0;
                        r_ff_idx <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_state  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_data_in <= AES_vec_data;
                    r_key_in  <= AES_vec_key;
                    r_expect  <= AES_vec_expect;
                    r_wait    <= '0;
                    r_en      <= 1'b1;
                    r_state   <= S_RUN;
                end

                S_RUN: begin
                    r_wait <= w_wait_next;
                    // A response in the final allowed cycle still counts:
                    // valid is tested before the timeout.
                    if (AES_data_out_valid) begin
                        r_result <= AES_data_out;
                        r_en     <= 1'b0;
                        r_state  <= S_CHECK;
                    end else if (w_timeout) begin
                        r_en    <= 1'b0;
                        r_fail  <= w_fail_inc;
                        r_tflag <= 1'b1;
                        if (r_fail == '0) begin
                            r_ff_idx <= r_idx;
                        end
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end
                end

                S_CHECK: begin
                    if (w_match) begin
                        r_pass <= w_pass_inc;
                    end else begin
                        r_fail <= w_fail_inc;
                        if (r_fail == '0) begin
                            r_ff_idx <= r_idx;
                        end
                    end
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end

                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (r_idx == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign AES_vec_idx        = r_idx;
    assign AES_en             = r_en;
    assign AES_data_in        = r_data_in;
    assign AES_key_in         = r_key_in;
    assign AES_busy           = r_busy;
    assign AES_done           = r_done;
    assign AES_pass_cnt       = r_pass;
    assign AES_fail_cnt       = r_fail;
    assign AES_timeout_flag   = r_tflag;
    assign AES_first_fail_idx = r_ff_idx;
    assign AES_dbg_state      = r_state;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for aes_vector_sequencer: a table of vectors, a behavioural core that
// answers after a chosen latency (or never), and a model that derives the
// expected run result, AES_en pulse widths and gaps from the per-vector
// latency/result rules.
// ---------------------------------------------------------------------------
module tb_aes_vector_sequencer;

    localparam int DATA_W     = 128;
    localparam int KEY_W      = 128;
    localparam int NUM_VEC    = 4;
    localparam int IDX_W      = 2;
    localparam int TIMEOUT    = 63;
    localparam int GAP_CYCLES = 2;
    localparam int CNT_W      = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    logic [IDX_W-1:0]  vec_idx;
    logic [DATA_W-1:0] vec_data;
    logic [KEY_W-1:0]  vec_key;
    logic [DATA_W-1:0] vec_expect;
    logic              en;
    logic [DATA_W-1:0] data_in;
    logic [KEY_W-1:0]  key_in;
    logic [DATA_W-1:0] data_out = '0;
    logic              data_out_valid = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              timeout_flag;
    logic [IDX_W-1:0]  first_fail_idx;
    logic [2:0]        dbg_state;

    // Vector table and the ciphertext the core model will return.
    logic [DATA_W-1:0] tb_pt  [NUM_VEC];
    logic [KEY_W-1:0]  tb_key [NUM_VEC];
    logic [DATA_W-1:0] tb_ct  [NUM_VEC];
    logic [DATA_W-1:0] tb_exp [NUM_VEC];

    assign vec_data   = tb_pt[vec_idx];
    assign vec_key    = tb_key[vec_idx];
    assign vec_expect = tb_exp[vec_idx];

    aes_vector_sequencer #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .NUM_VEC(NUM_VEC), .IDX_W(IDX_W),
        .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .AES_clk(clk),
        .AES_rst(rst),
        .AES_start(start),
        .AES_vec_idx(vec_idx),
        .AES_vec_data(vec_data),
        .AES_vec_key(vec_key),
        .AES_vec_expect(vec_expect),
        .AES_en(en),
        .AES_data_in(data_in),
        .AES_key_in(key_in),
        .AES_data_out(data_out),
        .AES_data_out_valid(data_out_valid),
        .AES_busy(busy),
        .AES_done(done),
        .AES_pass_cnt(pass_cnt),
        .AES_fail_cnt(fail_cnt),
        .AES_timeout_flag(timeout_flag),
        .AES_first_fail_idx(first_fail_idx),
        .AES_dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- core model ----------------
    // lat_cfg[v]: RUN cycle (1-based) on which valid is raised; 0 = never.
    int lat_cfg [NUM_VEC];
    bit spur_on = 1'b0;
    int run_cyc = 0;

    always @(negedge clk) begin
        if (en) begin
            run_cyc        = run_cyc + 1;
            data_out_valid = (run_cyc == lat_cfg[vec_idx]);
            data_out       = tb_ct[vec_idx];
        end else begin
            run_cyc        = 0;
            data_out_valid = spur_on && ($urandom_range(0, 1) == 1);
            data_out       = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] en_q  [$];   // expected AES_en pulse widths, in order
    logic [31:0] gap_q [$];   // expected AES_en low widths between vectors
    int exp_pass, exp_fail, exp_ff, exp_total;
    bit exp_to;

    task automatic build_model();
        int prev_low;
        en_q.delete();
        gap_q.delete();
        exp_pass = 0; exp_fail = 0; exp_ff = 0; exp_total = 0; exp_to = 1'b0;
        prev_low = 0;
        for (int v = 0; v < NUM_VEC; v++) begin
            if (v > 0) gap_q.push_back(prev_low);
            if (lat_cfg[v] < 1 || lat_cfg[v] > TIMEOUT) begin
                // No answer in time: LOAD, TIMEOUT RUN cycles, then GAP.
                en_q.push_back(TIMEOUT);
                exp_to = 1'b1;
                if (exp_fail == 0) exp_ff = v;
                exp_fail++;
                exp_total += 1 + TIMEOUT + GAP_CYCLES;
                prev_low = GAP_CYCLES + 1;
            end else begin
                en_q.push_back(lat_cfg[v]);
                if (tb_exp[v] == tb_ct[v]) begin
                    exp_pass++;
                end else begin
                    if (exp_fail == 0) exp_ff = v;
                    exp_fail++;
                end
                exp_total += 1 + lat_cfg[v] + 1 + GAP_CYCLES;
                prev_low = 1 + GAP_CYCLES + 1;  // CHECK + GAP + next LOAD
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    bit mon_on = 1'b0;
    int hi_len = 0;
    int lo_len = 0;
    int vec_n  = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (en) begin
                if (hi_len == 0) begin
                    if (vec_n > 0) begin
                        if (gap_q.size() == 0) check_val("gap_extra", 1, 0);
                        else check_val("en_gap", lo_len, gap_q.pop_front());
                    end
                    if (vec_n < NUM_VEC) begin
                        check_val("vec_idx", vec_idx, vec_n);
                        check_val("data_in", data_in, tb_pt[vec_n]);
                        check_val("key_in", key_in, tb_key[vec_n]);
                    end
                end
                hi_len++;
                lo_len = 0;
            end else begin
                if (hi_len != 0) begin
                    if (en_q.size() == 0) check_val("en_extra", 1, 0);
                    else check_val("en_len", hi_len, en_q.pop_front());
                    vec_n++;
                    hi_len = 0;
                end
                lo_len++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic new_table(input bit fips);
        for (int v = 0; v < NUM_VEC; v++) begin
            tb_pt[v]  = {$urandom, $urandom, $urandom, $urandom};
            tb_key[v] = {$urandom, $urandom, $urandom, $urandom};
            tb_ct[v]  = {$urandom, $urandom, $urandom, $urandom};
            tb_exp[v] = tb_ct[v];
        end
        if (fips) begin
            tb_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
            tb_pt[0]  = 128'h00112233445566778899aabbccddeeff;
            tb_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            tb_exp[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        end
    endtask

    task automatic corrupt(input int v, input int bitpos);
        logic [DATA_W-1:0] m;
        m = '0;
        m[bitpos] = 1'b1;
        tb_exp[v] = tb_ct[v] ^ m;
    endtask

    // Runs one full table; optionally pulses start again while busy.
    task automatic do_run(input bit busy_start);
        int n;
        int mid;
        bit got;
        build_model();
        mid = busy_start ? $urandom_range(2, exp_total - 2) : 0;
        vec_n = 0; hi_len = 0; lo_len = 0; mon_on = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_val("done_drop", done, 0);
        check_val("busy_hi", busy, 1);
        n = 0;
        got = 1'b0;
        while (!got && n < 2000) begin
            @(posedge clk); #1;
            n++;
            start = (mid != 0 && n == mid);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        mon_on = 1'b0;
        check_val("done_seen", got, 1);
        check_val("run_cycles", n, exp_total);
        check_val("busy_lo", busy, 0);
        check_val("en_lo", en, 0);
        check_val("pass_cnt", pass_cnt, exp_pass);
        check_val("fail_cnt", fail_cnt, exp_fail);
        check_val("timeout_flag", timeout_flag, exp_to);
        if (exp_fail != 0) check_val("first_fail_idx", first_fail_idx, exp_ff);
        check_val("en_left", en_q.size(), 0);
        check_val("vec_count", vec_n, NUM_VEC);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_en"}, en, 0);
        check_val({tag, "_data_in"}, data_in, 0);
        check_val({tag, "_key_in"}, key_in, 0);
        check_val({tag, "_pass"}, pass_cnt, 0);
        check_val({tag, "_fail"}, fail_cnt, 0);
        check_val({tag, "_tflag"}, timeout_flag, 0);
        check_val({tag, "_ff"}, first_fail_idx, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_idx"}, vec_idx, 0);
        check_val({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        bit found;
        rst = 1'b1;
        start = 1'b0;
        new_table(1'b0);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = 11;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle");

        // FIPS-197 vector first, core latency 11 everywhere.
        new_table(1'b1);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = 11;
        do_run(1'b0);

        // Vector 2 expected value wrong in bit 0.
        new_table(1'b0);
        corrupt(2, 0);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = $urandom_range(1, 40);
        do_run(1'b0);

        // Core never answers.
        new_table(1'b0);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = 0;
        do_run(1'b0);

        // Answer on the last allowed cycle wins over the timeout.
        new_table(1'b0);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = TIMEOUT;
        do_run(1'b0);

        // Start while busy and spurious valids outside RUN.
        new_table(1'b0);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = $urandom_range(1, 20);
        spur_on = 1'b1;
        do_run(1'b1);
        spur_on = 1'b0;

        // Random mixes.
        for (int r = 0; r < 8; r++) begin
            new_table(1'b0);
            for (int v = 0; v < NUM_VEC; v++) begin
                k = $urandom_range(0, 9);
                if (k == 0)      lat_cfg[v] = 0;
                else if (k == 1) lat_cfg[v] = TIMEOUT;
                else if (k == 2) lat_cfg[v] = TIMEOUT - 1;
                else             lat_cfg[v] = $urandom_range(1, 30);
                if ($urandom_range(0, 3) == 0) corrupt(v, $urandom_range(0, DATA_W - 1));
            end
            spur_on = ($urandom_range(0, 1) == 1);
            do_run($urandom_range(0, 1) == 1);
            spur_on = 1'b0;
        end

        // Asynchronous reset during RUN of vector 1.
        new_table(1'b0);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = 11;
        build_model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk); #1;
            if (en && vec_idx == 1) found = 1'b1;
        end
        check_val("reach_vec1", found, 1);
        check_val("pre_rst_pass", pass_cnt, 1);
        #1 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("post_rst");
        new_table(1'b0);
        for (int v = 0; v < NUM_VEC; v++) lat_cfg[v] = $urandom_range(1, 15);
        do_run(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=stalled want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
